// File: rtl/uriscv_mem_arbiter.sv
// rtl/uriscv_mem_arbiter.sv - fetch/LSU shared memory bus arbiter with in-order response routing
// Data has priority over fetch; a starvation counter forces fetch ahead after STARVE_LIMIT data grants.
module uriscv_mem_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifetch_rd_i,
    input  logic [31:0] ifetch_addr_i,
    output logic        ifetch_accept_o,
    output logic        ifetch_ack_o,
    output logic [31:0] ifetch_data_o,
    output logic        ifetch_error_o,

    input  logic        dmem_rd_i,
    input  logic [3:0]  dmem_wr_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    output logic        dmem_accept_o,
    output logic        dmem_ack_o,
    output logic [31:0] dmem_data_o,
    output logic        dmem_error_o,

    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_error_i,

    output logic        spurious_ack_o
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [OUTSTANDING-1:0] id_q, id_d;
    logic                   lock_q, lock_d;
    logic                   lock_port_q, lock_port_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   spurious_q, spurious_d;

    logic fetch_req;
    logic data_req;
    logic full;
    logic empty;
    logic sel_data;
    logic grant_data;
    logic req_pending;
    logic fwd;
    logic accept;
    logic pop;
    logic head_id;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fetch_req = ifetch_rd_i;
    assign data_req  = dmem_rd_i | (|dmem_wr_i);
    assign full      = (count_q == CW'(OUTSTANDING));
    assign empty     = (count_q == '0);

    // Port ID 1 = data, 0 = fetch; a stalled request keeps its port via the lock.
    assign sel_data    = data_req & ~(fetch_req & (starve_q == SW'(STARVE_LIMIT)));
    assign grant_data  = lock_q ? lock_port_q : sel_data;
    assign req_pending = grant_data ? data_req : fetch_req;
    assign fwd         = req_pending & ~full & rst;
    assign accept      = fwd & mem_accept_i;

    assign mem_rd_o   = fwd & (grant_data ? dmem_rd_i : 1'b1);
    assign mem_wr_o   = (fwd & grant_data) ? dmem_wr_i : 4'b0;
    assign mem_addr_o = grant_data ? dmem_addr_i : ifetch_addr_i;
    assign mem_data_o = dmem_data_i;

    assign ifetch_accept_o = accept & ~grant_data;
    assign dmem_accept_o   = accept & grant_data;

    assign pop     = mem_ack_i & ~empty;
    assign head_id = id_q[rd_ptr_q];

    assign ifetch_ack_o   = pop & ~head_id;
    assign dmem_ack_o     = pop & head_id;
    assign ifetch_data_o  = mem_data_i;
    assign dmem_data_o    = mem_data_i;
    assign ifetch_error_o = mem_error_i & ifetch_ack_o;
    assign dmem_error_o   = mem_error_i & dmem_ack_o;
    assign spurious_ack_o = spurious_q;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        id_d        = id_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        starve_d    = starve_q;
        spurious_d  = spurious_q;

        if (accept) begin
            id_d[wr_ptr_q] = grant_data;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (mem_ack_i & empty) begin
            spurious_d = 1'b1;
        end

        if (fwd & ~mem_accept_i) begin
            lock_d      = 1'b1;
            lock_port_d = grant_data;
        end else if (accept) begin
            lock_d = 1'b0;
        end

        if (~fetch_req | ifetch_accept_o) begin
            starve_d = '0;
        end else if (dmem_accept_o && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            id_q        <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            starve_q    <= '0;
            spurious_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            id_q        <= id_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            starve_q    <= starve_d;
            spurious_q  <= spurious_d;
        end
    end

endmodule

// File: doc/uriscv_mem_arbiter.md
# uriscv_mem_arbiter

Two-port arbiter that shares the core's single memory bus between instruction fetch and the LSU. It sits between the core's fetch/LSU request paths and the external memory port. It tracks outstanding transactions in an in-order ID FIFO and routes each response back to its originator. Fixed data-over-fetch priority applies, with a starvation guard so fetch is never locked out.

## Interface
- OUTSTANDING, 2: max accepted-but-unacknowledged transactions (1..4); ID FIFO depth.
- STARVE_LIMIT, 4: consecutive data grants with fetch waiting before fetch is forced ahead (1..15).
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ifetch_rd_i  input  1  fetch read request.
- ifetch_addr_i  input  32  fetch address.
- ifetch_accept_o  output  1  fetch request taken this cycle.
- ifetch_ack_o  output  1  fetch response valid.
- ifetch_data_o  output  32  fetch read data.
- ifetch_error_o  output  1  fetch bus error, qualified by ack.
- dmem_rd_i  input  1  LSU read request.
- dmem_wr_i  input  4  LSU byte write strobes; nonzero = write request.
- dmem_addr_i  input  32  LSU address.
- dmem_data_i  input  32  LSU write data.
- dmem_accept_o  output  1  LSU request taken this cycle.
- dmem_ack_o  output  1  LSU response valid.
- dmem_data_o  output  32  LSU read data.
- dmem_error_o  output  1  LSU bus error, qualified by ack.
- mem_rd_o  output  1  downstream read.
- mem_wr_o  output  4  downstream write strobes.
- mem_addr_o  output  32  downstream address.
- mem_data_o  output  32  downstream write data.
- mem_accept_i  input  1  downstream takes request.
- mem_ack_i  input  1  downstream response.
- mem_data_i  input  32  downstream read data.
- mem_error_i  input  1  downstream error, qualified by ack.
- spurious_ack_o  output  1  sticky: ack seen with no transaction outstanding.

## Operation
- Request pending: fetch = ifetch_rd_i; data = dmem_rd_i | (|dmem_wr_i). Requesters hold request fields stable until accepted.
- Grant selection happens only when unlocked:
  - Data wins by default.
  - Fetch wins if only fetch is pending, or if starve_cnt == STARVE_LIMIT.
- Lock register: set when a granted request is presented but mem_accept_i=0. The grant is then held to the same port until accept, so downstream sees no request switching.
- Downstream muxed from the granted port. mem_rd_o/mem_wr_o are forced 0 when the FIFO is full, when no request is pending, or when rst is low.
- x_accept_o = mem_accept_i & granted(x) & ~full.
- On accept: push the port ID (0 = fetch, 1 = data) into the FIFO. Writes occupy an entry as well; every accepted transaction receives exactly one ack.
- On mem_ack_i: pop the head ID. Assert that port's ack_o with mem_data_i and mem_error_i passed through combinationally. The other port's ack is 0.
- Ack while the FIFO is empty: ignored and not routed; sets spurious_ack_o, which clears only on reset.
- starve_cnt:
  - Increments on a data accept while fetch is pending.
  - Clears on a fetch accept, or when fetch is not pending.
  - Saturates at STARVE_LIMIT.
- Counter widths: occupancy count is clog2(OUTSTANDING+1) bits. Pointers wrap modulo OUTSTANDING.

## Timing
- Reset (async assert): FIFO empty, count=0, lock=0, starve_cnt=0, spurious_ack_o=0. All strobe/valid outputs are 0; data outputs are don't-care but are driven from mem_data_i / granted port.
- Request-to-downstream and accept-to-upstream paths are combinational (zero latency). Grant, lock, FIFO, and counters are registered.
- Response latency equals downstream latency plus 0; ack_o is combinational from mem_ack_i.
- Accept and ack in the same cycle: push and pop together, count unchanged. This is legal even when full, but accept is still blocked while full in that cycle because full is evaluated on the registered count.
- Full (count == OUTSTANDING): no request is forwarded and both accepts are 0. The lock is retained.
- Responses are strictly in order; no reordering.
- Reset mid-transaction: outstanding state is discarded. Acks arriving after reset release are treated as spurious.

## Test plan
- Fetch alone, addr 0x100, accept same cycle, ack 2 cycles later with data 0xDEADBEEF -> ifetch_accept_o=1 in cycle 0, ifetch_ack_o=1 with data 0xDEADBEEF, dmem_ack_o=0.
- Fetch and data read requested simultaneously, mem_accept_i=1 -> data accepted first, fetch accepted next cycle; acks return in order data then fetch.
- Data request held with mem_accept_i=0 for 3 cycles while fetch also requests -> mem_addr_o stays at the data address all 3 cycles; only dmem_accept_o pulses on accept.
- Continuous data and fetch requests, STARVE_LIMIT=4 -> 4 data accepts, then 1 fetch accept, repeating.
- OUTSTANDING=2, two accepts with no ack -> third request sees mem_rd_o=0 and accept=0; one ack frees a slot and the next accept occurs the following cycle.
- Ack with FIFO empty -> neither ack_o asserts, spurious_ack_o=1 and stays set until rst low.
